// File: rtl/sdrc_arb_pkg.sv
// sdrc_arb_pkg: shared state encoding and default widths for the request arbiter
package sdrc_arb_pkg;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_GRANT = 1'b1} arb_state_e;
  localparam int DEF_APP_AW   = 26;
  localparam int DEF_APP_RW   = 9;
  localparam int DEF_REQ_ID_W = 4;
endpackage

// File: rtl/sdrc_rr_pick.sv
// sdrc_rr_pick: combinational round-robin picker, first request at or after ptr
module sdrc_rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int PW        = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PW-1:0]        ptr,
  output logic [PW-1:0]        idx,
  output logic                 vld
);
  function automatic logic [PW-1:0] slot(input logic [PW-1:0] p, input int i);
    int c;
    c = int'(p) + i;
    return PW'(c > NUM_PORTS - 1 ? c - NUM_PORTS : c);
  endfunction
  // scan from farthest to nearest so the port closest to ptr is assigned last
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[slot(ptr, i)]) begin
        idx = slot(ptr, i);
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sdrc_req_arb.sv
// sdrc_req_arb: N-port round-robin arbiter in front of sdrc_req_gen
// SDRC_ARB_P0_PRIO_EN gives port 0 strict priority; others rotate among themselves.
module sdrc_req_arb
  import sdrc_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PW        = 2,
  parameter int APP_AW    = DEF_APP_AW,
  parameter int APP_RW    = DEF_APP_RW,
  parameter int REQ_ID_W  = DEF_REQ_ID_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          p_req,
  input  logic [NUM_PORTS*REQ_ID_W-1:0] p_id,
  input  logic [NUM_PORTS*APP_AW-1:0]   p_addr,
  input  logic [NUM_PORTS*APP_RW-1:0]   p_len,
  input  logic [NUM_PORTS-1:0]          p_wr_n,
  input  logic [NUM_PORTS-1:0]          p_wrap,
  output logic [NUM_PORTS-1:0]          p_ack,
  output logic                          req,
  output logic [REQ_ID_W-1:0]           req_id,
  output logic [APP_AW-1:0]             req_addr,
  output logic [APP_RW-1:0]             req_len,
  output logic                          req_wr_n,
  output logic                          req_wrap,
  input  logic                          req_ack,
  output logic [PW-1:0]                 grant_port,
  output logic                          arb_busy
);
  arb_state_e state, state_nxt;
  logic [PW-1:0] rr_ptr, rr_idx, rr_nxt, win;
  logic [NUM_PORTS-1:0] pick_req;
  logic rr_vld, win_vld, take, done;
  logic [REQ_ID_W-1:0] id_a [NUM_PORTS];
  logic [APP_AW-1:0] addr_a [NUM_PORTS];
  logic [APP_RW-1:0] len_a [NUM_PORTS];

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_unpack
    assign id_a[k]   = p_id[k*REQ_ID_W +: REQ_ID_W];
    assign addr_a[k] = p_addr[k*APP_AW +: APP_AW];
    assign len_a[k]  = p_len[k*APP_RW +: APP_RW];
  end

`ifdef SDRC_ARB_P0_PRIO_EN
  assign pick_req = {p_req[NUM_PORTS-1:1], 1'b0};
  assign win      = p_req[0] ? '0 : rr_idx;
  assign win_vld  = p_req[0] | rr_vld;
`else
  assign pick_req = p_req;
  assign win      = rr_idx;
  assign win_vld  = rr_vld;
`endif

  sdrc_rr_pick #(.NUM_PORTS(NUM_PORTS), .PW(PW)) u_pick (
    .req(pick_req),
    .ptr(rr_ptr),
    .idx(rr_idx),
    .vld(rr_vld)
  );

  always_comb begin
    take      = (state == ARB_IDLE) && win_vld;
    done      = (state == ARB_GRANT) && req_ack;
    state_nxt = (state == ARB_IDLE) ? (win_vld ? ARB_GRANT : ARB_IDLE)
                                    : (req_ack ? ARB_IDLE : ARB_GRANT);
    rr_nxt    = (grant_port == PW'(NUM_PORTS - 1)) ? '0 : grant_port + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else state <= state_nxt;
  end

  assign req      = (state == ARB_GRANT);
  assign arb_busy = (state == ARB_GRANT);

  always_ff @(posedge clk) begin
    if (reset) begin
      p_ack      <= '0;
      req_id     <= '0;
      req_addr   <= '0;
      req_len    <= '0;
      req_wr_n   <= 1'b0;
      req_wrap   <= 1'b0;
      grant_port <= '0;
      rr_ptr     <= '0;
    end else begin
      p_ack <= done ? (NUM_PORTS'(1) << grant_port) : '0;
      if (take) begin
        req_id     <= id_a[win];
        req_addr   <= addr_a[win];
        req_len    <= len_a[win];
        req_wr_n   <= p_wr_n[win];
        req_wrap   <= p_wrap[win];
        grant_port <= win;
      end
`ifdef SDRC_ARB_P0_PRIO_EN
      if (done && grant_port != '0) rr_ptr <= rr_nxt;
`else
      if (done) rr_ptr <= rr_nxt;
`endif
    end
  end
endmodule
